// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic-array control blocks.
package systolic_pkg;

    // Weight-load sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        GAP     = 2'd2,
        DONE    = 2'd3
    } wseq_state_t;

    // Default number of rows in one weight tile (matches the PE array height).
    localparam int ROWS_DEFAULT = 8;

    // Default settle gap between tiles and width of the tile counters.
    localparam int GAP_DEFAULT    = 1;
    localparam int TILE_W_DEFAULT = 4;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with programmable rollover value and synchronous clear.
// Counts 0..rollover_val on count_enable, then wraps back to 0.
module flex_counter #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            clear,
    input  logic            count_enable,
    input  logic [SIZE-1:0] rollover_val,
    output logic [SIZE-1:0] count_out,
    output logic            rollover_flag
);

    logic [SIZE-1:0] count_q;
    logic [SIZE-1:0] count_d;

    // Flag is high while the counter sits on its last value, so the owner can
    // qualify it with count_enable to detect the wrapping increment.
    assign rollover_flag = (count_q == rollover_val);
    assign count_out     = count_q;

    // Next count: clear wins, otherwise increment with wrap at rollover_val.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/weight_load_sequencer.sv
// Weight-load controller for the systolic array. A trigger loads a programmable
// number of tiles, each ROWS accepted rows deep, with an optional settle gap
// between tiles. Supports upstream stall, abort and busy/done status.
module weight_load_sequencer #(
    parameter int ROWS   = systolic_pkg::ROWS_DEFAULT,
    parameter int GAP    = systolic_pkg::GAP_DEFAULT,
    parameter int TILE_W = systolic_pkg::TILE_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    trigger_weight,
    input  logic [TILE_W-1:0]       tile_count,
    input  logic                    weight_valid,
    input  logic                    abort,
    output logic                    load,
    output logic [$clog2(ROWS)-1:0] row_idx,
    output logic [TILE_W-1:0]       tile_idx,
    output logic                    busy,
    output logic                    done
);

    import systolic_pkg::*;

    localparam int ROW_W = $clog2(ROWS);
    // Keep the gap counter at least one bit wide even when GAP is 0 or 1.
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

    wseq_state_t       state_q;
    logic [TILE_W-1:0] tile_q;      // tile currently being loaded
    logic [TILE_W-1:0] tiles_q;     // tile_count captured at trigger
    logic [GAP_W-1:0]  gap_q;       // cycles spent in the current gap

    logic              row_clear;
    logic              row_at_last;
    logic              last_accept;
    logic              run_active;

    // The array shifts a row only when the buffer has one and we are not cancelling.
    assign load        = (state_q == LOADING) && weight_valid && !abort;
    assign busy        = (state_q == LOADING) || (state_q == systolic_pkg::GAP);
    assign done        = (state_q == DONE);
    assign tile_idx    = tile_q;
    assign run_active  = (state_q != IDLE);

    // Row counter is parked at 0 outside a run and when a run is cancelled.
    assign row_clear   = (state_q == IDLE) || (state_q == DONE) || abort;
    assign last_accept = load && row_at_last;

    flex_counter #(
        .SIZE (ROW_W)
    ) u_row_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (row_clear),
        .count_enable  (load),
        .rollover_val  (LAST_ROW),
        .count_out     (row_idx),
        .rollover_flag (row_at_last)
    );

    // Sequencer FSM with tile, gap and captured-count registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            tile_q  <= '0;
            tiles_q <= '0;
            gap_q   <= '0;
        end else if (abort && run_active) begin
            // Cancel takes priority over every other transition; no done pulse.
            state_q <= IDLE;
            tile_q  <= '0;
            gap_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trigger_weight) begin
                        tile_q <= '0;
                        gap_q  <= '0;
                        if (tile_count != '0) begin
                            tiles_q <= tile_count;
                            state_q <= LOADING;
                        end else begin
                            // Empty request completes immediately.
                            state_q <= DONE;
                        end
                    end
                end
                LOADING: begin
                    if (last_accept) begin
                        if (tile_q == tiles_q - 1'b1) begin
                            tile_q  <= '0;
                            state_q <= DONE;
                        end else begin
                            tile_q <= tile_q + 1'b1;
                            if (GAP == 0) begin
                                state_q <= LOADING;
                            end else begin
                                state_q <= systolic_pkg::GAP;
                            end
                        end
                    end
                end
                systolic_pkg::GAP: begin
                    if (gap_q == LAST_GAP) begin
                        gap_q   <= '0;
                        state_q <= LOADING;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                DONE: begin
                    tile_q  <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    tile_q  <= '0;
                    gap_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Directed bench for weight_load_sequencer with ROWS=8, GAP=1, TILE_W=4.
// Inputs change 2 time units after a rising edge; outputs are checked 1 unit later.
module tb_weight_load_sequencer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       trigger_weight;
    logic [3:0] tile_count;
    logic       weight_valid;
    logic       abort;
    logic       load;
    logic [2:0] row_idx;
    logic [3:0] tile_idx;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    weight_load_sequencer #(
        .ROWS   (8),
        .GAP    (1),
        .TILE_W (4)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .trigger_weight (trigger_weight),
        .tile_count     (tile_count),
        .weight_valid   (weight_valid),
        .abort          (abort),
        .load           (load),
        .row_idx        (row_idx),
        .tile_idx       (tile_idx),
        .busy           (busy),
        .done           (done)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Let combinational outputs settle, then check every output for this cycle.
    task automatic expect_out(input string tag, input logic l, input int r, input int t,
                              input logic b, input logic d);
        #1;
        check_val({tag, ".load"}, 32'(load), 32'(l));
        check_val({tag, ".row"},  32'(row_idx), r);
        check_val({tag, ".tile"}, 32'(tile_idx), t);
        check_val({tag, ".busy"}, 32'(busy), 32'(b));
        check_val({tag, ".done"}, 32'(done), 32'(d));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Eight unstalled rows of one tile, one check line per cycle.
    task automatic run_tile(input string tag, input int tile);
        for (int i = 0; i < 8; i++) begin
            expect_out($sformatf("%s.r%0d", tag, i), 1'b1, i, tile, 1'b1, 1'b0);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        n_rst          = 1'b1;
        trigger_weight = 1'b0;
        tile_count     = 4'd0;
        weight_valid   = 1'b0;
        abort          = 1'b0;
        #1 n_rst = 1'b0;
        expect_out("reset", 1'b0, 0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2 n_rst = 1'b1;
        expect_out("post_reset", 1'b0, 0, 0, 1'b0, 1'b0);

        // 1: single tile, no stall -> load t+1..t+8, done t+9.
        tick();
        trigger_weight = 1'b1; tile_count = 4'd1; weight_valid = 1'b1;
        expect_out("t1.trig", 1'b0, 0, 0, 1'b0, 1'b0);
        tick();
        trigger_weight = 1'b0;
        run_tile("t1", 0);
        expect_out("t1.done", 1'b0, 0, 0, 1'b0, 1'b1);
        tick();
        expect_out("t1.idle", 1'b0, 0, 0, 1'b0, 1'b0);

        // 2: two tiles with a one-cycle gap -> done at t+18.
        tick();
        trigger_weight = 1'b1; tile_count = 4'd2;
        expect_out("t2.trig", 1'b0, 0, 0, 1'b0, 1'b0);
        tick();
        trigger_weight = 1'b0;
        run_tile("t2.a", 0);
        expect_out("t2.gap", 1'b0, 0, 1, 1'b1, 1'b0);
        tick();
        run_tile("t2.b", 1);
        expect_out("t2.done", 1'b0, 0, 0, 1'b0, 1'b1);
        tick();
        expect_out("t2.idle", 1'b0, 0, 0, 1'b0, 1'b0);

        // 3: valid alternating 1/0 -> 8 loads over 15 cycles, done on cycle 16.
        tick();
        trigger_weight = 1'b1; tile_count = 4'd1;
        expect_out("t3.trig", 1'b0, 0, 0, 1'b0, 1'b0);
        tick();
        trigger_weight = 1'b0;
        for (int j = 0; j < 15; j++) begin
            weight_valid = (j % 2 == 0);
            expect_out($sformatf("t3.c%0d", j), weight_valid, (j + 1) / 2, 0, 1'b1, 1'b0);
            tick();
        end
        weight_valid = 1'b1;
        expect_out("t3.done", 1'b0, 0, 0, 1'b0, 1'b1);
        tick();
        expect_out("t3.idle", 1'b0, 0, 0, 1'b0, 1'b0);

        // 4: abort at row 3 -> load drops same cycle, IDLE next, no done; restart.
        tick();
        trigger_weight = 1'b1; tile_count = 4'd2;
        expect_out("t4.trig", 1'b0, 0, 0, 1'b0, 1'b0);
        tick();
        trigger_weight = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_out($sformatf("t4.r%0d", i), 1'b1, i, 0, 1'b1, 1'b0);
            tick();
        end
        abort = 1'b1;
        expect_out("t4.abort", 1'b0, 3, 0, 1'b1, 1'b0);
        tick();
        abort = 1'b0;
        expect_out("t4.idle0", 1'b0, 0, 0, 1'b0, 1'b0);
        tick();
        expect_out("t4.idle1", 1'b0, 0, 0, 1'b0, 1'b0);
        trigger_weight = 1'b1; tile_count = 4'd1;
        tick();
        trigger_weight = 1'b0;
        run_tile("t4.re", 0);
        expect_out("t4.done", 1'b0, 0, 0, 1'b0, 1'b1);
        tick();

        // 5: trigger mid-run ignored; zero tiles -> done at t+1; abort in IDLE no effect.
        trigger_weight = 1'b1; tile_count = 4'd1;
        tick();
        trigger_weight = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                trigger_weight = 1'b1; tile_count = 4'd3;
            end else begin
                trigger_weight = 1'b0;
            end
            expect_out($sformatf("t5.r%0d", i), 1'b1, i, 0, 1'b1, 1'b0);
            tick();
        end
        trigger_weight = 1'b0;
        expect_out("t5.done", 1'b0, 0, 0, 1'b0, 1'b1);
        tick();
        expect_out("t5.noq", 1'b0, 0, 0, 1'b0, 1'b0);
        tick();
        trigger_weight = 1'b1; tile_count = 4'd0;
        expect_out("t5.ztrig", 1'b0, 0, 0, 1'b0, 1'b0);
        tick();
        trigger_weight = 1'b0;
        expect_out("t5.zdone", 1'b0, 0, 0, 1'b0, 1'b1);
        tick();
        expect_out("t5.zidle", 1'b0, 0, 0, 1'b0, 1'b0);
        trigger_weight = 1'b1; tile_count = 4'd1; abort = 1'b1;
        tick();
        trigger_weight = 1'b0; abort = 1'b0;
        run_tile("t5.ab", 0);
        expect_out("t5.abdone", 1'b0, 0, 0, 1'b0, 1'b1);
        tick();

        // 6: async reset during GAP -> outputs drop immediately, idle afterwards.
        trigger_weight = 1'b1; tile_count = 4'd2;
        tick();
        trigger_weight = 1'b0;
        run_tile("t6", 0);
        expect_out("t6.gap", 1'b0, 0, 1, 1'b1, 1'b0);
        n_rst = 1'b0;
        expect_out("t6.rst", 1'b0, 0, 0, 1'b0, 1'b0);
        tick();
        expect_out("t6.hold", 1'b0, 0, 0, 1'b0, 1'b0);
        tick();
        n_rst = 1'b1;
        expect_out("t6.rel", 1'b0, 0, 0, 1'b0, 1'b0);
        tick();
        expect_out("t6.idle0", 1'b0, 0, 0, 1'b0, 1'b0);
        tick();
        expect_out("t6.idle1", 1'b0, 0, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
